// File: rtl/clk_div_ctrl_if.sv
// Bundle of handshake, divider-control and status signals for clk_div_ctrl.
//   master : requester/divider side (drives requests and the divided clock)
//   slave  : the controller (drives ready pulses, COUNT_REG, DIV_RSTn, status)
interface clk_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_a_valid;
    logic [WIDTH-1:0] req_a_div;
    logic             req_a_ready;
    logic             req_b_valid;
    logic [WIDTH-1:0] req_b_div;
    logic             req_b_ready;
    logic             div_clk;
    logic [WIDTH-1:0] count_reg;
    logic             div_rstn;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_a_valid, req_a_div, req_b_valid, req_b_div, div_clk,
        input  req_a_ready, req_b_ready, count_reg, div_rstn, busy, done, err
    );

    modport slave (
        input  req_a_valid, req_a_div, req_b_valid, req_b_div, div_clk,
        output req_a_ready, req_b_ready, count_reg, div_rstn, busy, done, err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Pixel-clock divider configuration controller and two-way arbiter.
// Requester A (host) has fixed priority over requester B (loader). A granted
// terminal count is validated, then applied on a divider rising edge (or after
// a bounded wait) while the divider is held in reset for a settle window.
//
// Ports:
//   clk  : system clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : clk_div_ctrl_if.slave
//          req_a_* / req_b_*  valid/div in, one-cycle ready pulse out
//          div_clk            divided clock fed back (same clk domain)
//          count_reg          terminal count driven to the divider
//          div_rstn           divider reset, active-low
//          busy/done/err      status; done/err are one-cycle pulses
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate A over B, validate and latch the granted value
// WAIT_EDGE | wait for a divider rising edge or the edge timeout
// HOLD      | divider held in reset, new count applied, settle window
// FINISH    | one cycle, divider released, DONE/ERR pulse
module clk_div_ctrl #(
    parameter int WIDTH        = 32,
    parameter int DEFAULT_DIV  = 3,
    parameter int MIN_DIV      = 1,
    parameter int SETTLE       = 4,
    parameter int EDGE_TIMEOUT = 1023
) (
    input logic           clk,
    input logic           rst,
    clk_div_ctrl_if.slave bus
);

    localparam int TMO_W = $clog2(EDGE_TIMEOUT + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [WIDTH-1:0] DEF_V    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_DIV);
    // Leaving on the cycle whose count would reach EDGE_TIMEOUT bounds the
    // wait to exactly EDGE_TIMEOUT cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EDGE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(EDGE_TIMEOUT);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_EDGE,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] req_sel;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [SET_W-1:0] set_cnt, set_nxt;
    logic             div_clk_q;
    logic             rise;
    logic             grant;
    logic             ready_a_nxt, ready_b_nxt, done_nxt, err_nxt;

    assign rise = bus.div_clk & ~div_clk_q;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        count_nxt   = bus.count_reg;
        tmo_nxt     = tmo_cnt;
        set_nxt     = set_cnt;
        req_sel     = '0;
        grant       = 1'b0;
        ready_a_nxt = 1'b0;
        ready_b_nxt = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.req_a_valid) begin
                    grant       = 1'b1;
                    req_sel     = bus.req_a_div;
                    ready_a_nxt = 1'b1;
                end else if (bus.req_b_valid) begin
                    grant       = 1'b1;
                    req_sel     = bus.req_b_div;
                    ready_b_nxt = 1'b1;
                end
                if (grant) begin
                    pending_nxt = req_sel;
                    if (req_sel < MIN_V) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_FINISH;
                    end else if (req_sel == bus.count_reg) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        tmo_nxt   = '0;
                        state_nxt = S_WAIT_EDGE;
                    end
                end
            end
            S_WAIT_EDGE: begin
                if (rise || (tmo_cnt == TMO_LAST)) begin
                    count_nxt = pending;
                    set_nxt   = '0;
                    state_nxt = S_HOLD;
                end else if (tmo_cnt != TMO_MAX) begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            S_HOLD: begin
                if (set_cnt == SET_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_FINISH;
                end else begin
                    set_nxt = set_cnt + SET_W'(1);
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so that DIV_RSTn falls
    // and COUNT_REG changes in the same cycle HOLD is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pending         <= '0;
            tmo_cnt         <= '0;
            set_cnt         <= '0;
            div_clk_q       <= 1'b1;
            bus.count_reg   <= DEF_V;
            bus.div_rstn    <= 1'b0;
            bus.req_a_ready <= 1'b0;
            bus.req_b_ready <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            pending         <= pending_nxt;
            tmo_cnt         <= tmo_nxt;
            set_cnt         <= set_nxt;
            div_clk_q       <= bus.div_clk;
            bus.count_reg   <= count_nxt;
            bus.div_rstn    <= (state_nxt != S_HOLD);
            bus.req_a_ready <= ready_a_nxt;
            bus.req_b_ready <= ready_b_nxt;
            bus.busy        <= (state_nxt != S_IDLE);
            bus.done        <= done_nxt;
            bus.err         <= err_nxt;
        end
    end

endmodule
